// File: rtl/cache_ctrl_pkg.sv
// Shared types and mux encodings for the N-way cache controller.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_ALLOCATE,
    ST_FL_SCAN,
    ST_FL_WB,
    ST_FL_DONE
  } state_e;

  localparam logic [1:0] WSEL_NONE = 2'b00;
  localparam logic [1:0] WSEL_PMEM = 2'b01;
  localparam logic [1:0] WSEL_CPU  = 2'b10;

  localparam logic [1:0] ASEL_CPU    = 2'b00;
  localparam logic [1:0] ASEL_VICTIM = 2'b01;
  localparam logic [1:0] ASEL_FLUSH  = 2'b10;

endpackage

// File: rtl/nway_victim_sel.sv
// Hit-way decode (lowest matching way) and victim choice (lowest invalid way, else LRU).
module nway_victim_sel
  import cache_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = 4,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] hit_vec,
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic [WAY_W-1:0]    lru_victim,
  output logic                hit_c,
  output logic [WAY_W-1:0]    hit_way_c,
  output logic [WAY_W-1:0]    victim_c
);

  // Descending scan so the lowest-numbered qualifying way wins.
  always_comb begin
    hit_c     = |hit_vec;
    hit_way_c = '0;
    victim_c  = lru_victim;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i])    hit_way_c = WAY_W'(i);
      if (!valid_vec[i]) victim_c  = WAY_W'(i);
    end
  end

endmodule

// File: rtl/nway_cache_control.sv
// N-way set-associative L1 cache controller: hit/miss handling, writeback/allocate,
// and a flush walk that writes back every dirty line.
module nway_cache_control
  import cache_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = 4,
  parameter  int unsigned NUM_SETS = 8,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS),
  localparam int unsigned SET_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic [NUM_WAYS-1:0] hit_vec,
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic [NUM_WAYS-1:0] dirty_vec,
  input  logic [WAY_W-1:0]    lru_victim,
  input  logic                pmem_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [WAY_W-1:0]    way_sel,
  output logic [1:0]          write_sel,
  output logic [1:0]          addr_sel,
  output logic [NUM_WAYS-1:0] load_tag,
  output logic [NUM_WAYS-1:0] load_valid,
  output logic                set_valid,
  output logic [NUM_WAYS-1:0] load_dirty,
  output logic                set_dirty,
  output logic                load_lru,
  output logic [WAY_W-1:0]    lru_mru_way,
  input  logic                flush_req,
  output logic [SET_W-1:0]    flush_set,
  output logic                busy_flush,
  output logic                flush_done
);

  state_e             state, state_d;
  logic [WAY_W-1:0]   way_reg, way_d;
  logic [SET_W-1:0]   fl_set, fl_set_d, adv_set;
  logic [WAY_W-1:0]   fl_way, fl_way_d, adv_way;
  logic               last_way, last_set;
  logic               hit_c;
  logic [WAY_W-1:0]   hit_way_c, victim_c;

  nway_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_victim_sel (
    .hit_vec    (hit_vec),
    .valid_vec  (valid_vec),
    .lru_victim (lru_victim),
    .hit_c      (hit_c),
    .hit_way_c  (hit_way_c),
    .victim_c   (victim_c)
  );

  // Flush walk is way-major within a set; wraps to 0/0 after the last line.
  assign last_way  = (fl_way == WAY_W'(NUM_WAYS - 1));
  assign last_set  = (fl_set == SET_W'(NUM_SETS - 1));
  assign adv_way   = last_way ? '0 : fl_way + WAY_W'(1);
  assign adv_set   = last_way ? (last_set ? '0 : fl_set + SET_W'(1)) : fl_set;
  assign flush_set = fl_set;

  always_comb begin
    state_d     = state;
    way_d       = way_reg;
    fl_set_d    = fl_set;
    fl_way_d    = fl_way;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    way_sel     = '0;
    write_sel   = WSEL_NONE;
    addr_sel    = ASEL_CPU;
    load_tag    = '0;
    load_valid  = '0;
    set_valid   = 1'b0;
    load_dirty  = '0;
    set_dirty   = 1'b0;
    load_lru    = 1'b0;
    lru_mru_way = '0;
    busy_flush  = 1'b0;
    flush_done  = 1'b0;
    // Outputs are held quiet while reset is asserted, even with a request present.
    if (rst) begin
      case (state)
        ST_IDLE: begin
          if (mem_read || mem_write) begin
            if (hit_c) begin
              mem_resp    = 1'b1;
              way_sel     = hit_way_c;
              load_lru    = 1'b1;
              lru_mru_way = hit_way_c;
              if (mem_write) begin
                load_dirty[hit_way_c] = 1'b1;
                set_dirty             = 1'b1;
                write_sel             = WSEL_CPU;
              end
            end else begin
              way_d   = victim_c;
              state_d = dirty_vec[victim_c] ? ST_WRITEBACK : ST_ALLOCATE;
            end
          end else if (flush_req) begin
            fl_set_d = '0;
            fl_way_d = '0;
            state_d  = ST_FL_SCAN;
          end
        end
        ST_WRITEBACK: begin
          pmem_write = 1'b1;
          addr_sel   = ASEL_VICTIM;
          way_sel    = way_reg;
          if (pmem_resp) begin
            load_dirty[way_reg] = 1'b1;
            state_d             = ST_ALLOCATE;
          end
        end
        ST_ALLOCATE: begin
          pmem_read = 1'b1;
          way_sel   = way_reg;
          if (pmem_resp) begin
            write_sel           = WSEL_PMEM;
            load_tag[way_reg]   = 1'b1;
            load_valid[way_reg] = 1'b1;
            set_valid           = 1'b1;
            load_dirty[way_reg] = 1'b1;
            state_d             = ST_IDLE;
          end
        end
        ST_FL_SCAN: begin
          busy_flush = 1'b1;
          way_sel    = fl_way;
          if (valid_vec[fl_way] && dirty_vec[fl_way]) begin
            state_d = ST_FL_WB;
          end else begin
            fl_way_d = adv_way;
            fl_set_d = adv_set;
            state_d  = (last_way && last_set) ? ST_FL_DONE : ST_FL_SCAN;
          end
        end
        ST_FL_WB: begin
          busy_flush = 1'b1;
          pmem_write = 1'b1;
          addr_sel   = ASEL_FLUSH;
          way_sel    = fl_way;
          if (pmem_resp) begin
            load_dirty[fl_way] = 1'b1;
            fl_way_d           = adv_way;
            fl_set_d           = adv_set;
            state_d            = (last_way && last_set) ? ST_FL_DONE : ST_FL_SCAN;
          end
        end
        ST_FL_DONE: begin
          busy_flush = 1'b1;
          flush_done = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      way_reg <= '0;
      fl_set  <= '0;
      fl_way  <= '0;
    end else begin
      state   <= state_d;
      way_reg <= way_d;
      fl_set  <= fl_set_d;
      fl_way  <= fl_way_d;
    end
  end

endmodule

// File: tb/tb_nway_cache_control.sv
// Bench for nway_cache_control: directed protocol steps, then random traffic against a
// cache-level reference model with bench-held tag/valid/dirty/LRU arrays and a pmem responder.
module tb_nway_cache_control;

  logic       clk;
  logic       rst;
  logic       mem_read, mem_write, mem_resp;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic [1:0] lru_victim;
  logic       pmem_resp, pmem_read, pmem_write;
  logic [1:0] way_sel, write_sel, addr_sel;
  logic [3:0] load_tag, load_valid, load_dirty;
  logic       set_valid, set_dirty, load_lru;
  logic [1:0] lru_mru_way;
  logic       flush_req;
  logic [2:0] flush_set;
  logic       busy_flush, flush_done;
  logic [30:0] outs;

  int errors = 0;
  int nchecks = 0;

  nway_cache_control #(.NUM_WAYS(4), .NUM_SETS(8)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_victim(lru_victim),
    .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write), .way_sel(way_sel),
    .write_sel(write_sel), .addr_sel(addr_sel), .load_tag(load_tag), .load_valid(load_valid),
    .set_valid(set_valid), .load_dirty(load_dirty), .set_dirty(set_dirty), .load_lru(load_lru),
    .lru_mru_way(lru_mru_way), .flush_req(flush_req), .flush_set(flush_set),
    .busy_flush(busy_flush), .flush_done(flush_done)
  );

  assign outs = {mem_resp, pmem_read, pmem_write, way_sel, write_sel, addr_sel, load_tag,
                 load_valid, set_valid, load_dirty, set_dirty, load_lru, lru_mru_way,
                 flush_set, busy_flush, flush_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment arrays (updated from DUT strobes) and golden arrays (updated by cache rules)
  int unsigned etag [8][4];
  bit          evalid [8][4];
  bit          edirty [8][4];
  int unsigned estamp [8][4];
  int unsigned gtag [8][4];
  bit          gvalid [8][4];
  bit          gdirty [8][4];
  int unsigned gstamp [8][4];
  int unsigned enow = 0, gnow = 0;
  int          cur_set = 0;
  int unsigned cur_tag = 0;
  bit          pm_pend = 0;
  int          pm_wait = 0;

  int  nwb, nrd, nscan, both_hi, bad_fasel, resp_way, wb_way, wb_asel, rd_way, rd_asel;
  bit  got_resp, got_done, resp_sd;
  int  wb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int oldest(input int unsigned st [4]);
    int b = 0;
    for (int w = 1; w < 4; w++) if (st[w] < st[b]) b = w;
    return b;
  endfunction

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_inputs();
    int s;
    s = busy_flush ? int'(flush_set) : cur_set;
    for (int w = 0; w < 4; w++) begin
      hit_vec[w]   = evalid[s][w] && (etag[s][w] == cur_tag);
      valid_vec[w] = evalid[s][w];
      dirty_vec[w] = edirty[s][w];
    end
    lru_victim = 2'(oldest(estamp[s]));
    pmem_resp  = 1'b0;
    if (pm_pend) begin
      pm_wait--;
      if (pm_wait == 0) begin
        pmem_resp = 1'b1;
        pm_pend   = 0;
      end
    end
  endtask

  // One clock of the environment: sample outputs, apply strobes at the edge, redrive.
  task automatic tick();
    int s;
    logic [3:0] lt, lv, ld;
    logic sv, sd, ll;
    logic [1:0] lm;
    #1;
    s = busy_flush ? int'(flush_set) : cur_set;
    if (pmem_read && pmem_write) both_hi++;
    if ((pmem_read || pmem_write) && !pm_pend && !pmem_resp) begin
      pm_pend = 1;
      pm_wait = int'($urandom_range(1, 3));
    end
    if (pmem_resp && pmem_write) begin
      nwb++; wb_way = int'(way_sel); wb_asel = int'(addr_sel);
      if (busy_flush) begin
        wb_q.push_back(int'(flush_set) * 4 + int'(way_sel));
        if (addr_sel != 2'b10) bad_fasel++;
      end
    end
    if (pmem_resp && pmem_read) begin
      nrd++; rd_way = int'(way_sel); rd_asel = int'(addr_sel);
    end
    if (mem_resp) begin
      got_resp = 1; resp_way = int'(way_sel); resp_sd = set_dirty;
    end
    if (busy_flush && !pmem_write && !flush_done) nscan++;
    if (flush_done) got_done = 1;
    lt = load_tag; lv = load_valid; sv = set_valid; ld = load_dirty; sd = set_dirty;
    ll = load_lru; lm = lru_mru_way;
    @(posedge clk);
    for (int w = 0; w < 4; w++) begin
      if (lt[w]) etag[s][w] = cur_tag;
      if (lv[w]) evalid[s][w] = sv;
      if (ld[w]) edirty[s][w] = sd;
    end
    if (ll) begin
      enow++;
      estamp[s][lm] = enow;
    end
    @(negedge clk);
    drive_inputs();
  endtask

  task automatic do_op(input bit wr, input int s, input int unsigned t);
    int  hw, vic, cyc;
    bit  exp_wb, exp_rd;
    hw = -1;
    for (int w = 3; w >= 0; w--) if (gvalid[s][w] && gtag[s][w] == t) hw = w;
    if (hw >= 0) begin
      vic = hw; exp_wb = 0; exp_rd = 0;
      if (wr) gdirty[s][hw] = 1;
    end else begin
      vic = -1;
      for (int w = 3; w >= 0; w--) if (!gvalid[s][w]) vic = w;
      if (vic < 0) vic = oldest(gstamp[s]);
      exp_wb = gvalid[s][vic] && gdirty[s][vic];
      exp_rd = 1;
      gtag[s][vic] = t; gvalid[s][vic] = 1; gdirty[s][vic] = wr;
    end
    gnow++;
    gstamp[s][vic] = gnow;
    cur_set = s; cur_tag = t;
    mem_write = wr;
    mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_inputs();
    nwb = 0; nrd = 0; both_hi = 0; got_resp = 0; cyc = 0;
    while (cyc < 60 && !got_resp) begin
      tick();
      cyc++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    drive_inputs();
    check("op_resp_seen", 32'(got_resp), 32'd1);
    check("op_resp_way", 32'(resp_way), 32'(vic));
    check("op_resp_set_dirty", 32'(resp_sd), 32'(wr));
    check("op_writebacks", 32'(nwb), 32'(exp_wb));
    check("op_reads", 32'(nrd), 32'(exp_rd));
    check("op_pmem_exclusive", 32'(both_hi), 32'd0);
    if (hw >= 0) check("op_hit_latency", 32'(cyc), 32'd1);
    if (exp_wb) check("op_wb_way_asel", 32'(wb_way * 4 + wb_asel), 32'(vic * 4 + 1));
    if (exp_rd) check("op_rd_way_asel", 32'(rd_way * 4 + rd_asel), 32'(vic * 4));
  endtask

  task automatic do_flush();
    int exp_q[$];
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++)
        if (gvalid[s][w] && gdirty[s][w]) begin
          exp_q.push_back(s * 4 + w);
          gdirty[s][w] = 0;
        end
    wb_q.delete(); nscan = 0; got_done = 0; bad_fasel = 0; nwb = 0; both_hi = 0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int c = 0; c < 3000 && !got_done; c++) tick();
    check("flush_done_seen", 32'(got_done), 32'd1);
    check("flush_scans", 32'(nscan), 32'd32);
    check("flush_wb_count", 32'(wb_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wb_q.size(); i++)
      check($sformatf("flush_wb_line%0d", i), 32'(wb_q[i]), 32'(exp_q[i]));
    check("flush_addr_sel", 32'(bad_fasel), 32'd0);
    check("flush_pmem_exclusive", 32'(both_hi), 32'd0);
    check("flush_busy_after", 32'(busy_flush), 32'd0);
  endtask

  task automatic compare_arrays();
    logic [31:0] ev, gv;
    for (int s = 0; s < 8; s++) begin
      ev = '0; gv = '0;
      for (int w = 0; w < 4; w++) begin
        ev[w] = evalid[s][w]; ev[4 + w] = edirty[s][w];
        gv[w] = gvalid[s][w]; gv[4 + w] = gdirty[s][w];
        ev[8 + 4 * w +: 4] = evalid[s][w] ? 4'(etag[s][w]) : 4'h0;
        gv[8 + 4 * w +: 4] = gvalid[s][w] ? 4'(gtag[s][w]) : 4'h0;
      end
      check($sformatf("array_set%0d", s), ev, gv);
    end
  endtask

  task automatic clear_arrays();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) begin
        etag[s][w] = 0; evalid[s][w] = 0; edirty[s][w] = 0; estamp[s][w] = 0;
        gtag[s][w] = 0; gvalid[s][w] = 0; gdirty[s][w] = 0; gstamp[s][w] = 0;
      end
  endtask

  initial begin
    rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0; hit_vec = 4'b0100; valid_vec = 4'b0100;
    dirty_vec = 4'b0; lru_victim = 2'd0; pmem_resp = 1'b0; flush_req = 1'b0;
    clear_arrays();
    #3;
    check("reset_outs", 32'(outs), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs_held", 32'(outs), 32'd0);
    rst = 1'b1; mem_read = 1'b0; hit_vec = 4'b0;
    nxt();

    // Read hit on way 2
    mem_read = 1'b1; hit_vec = 4'b0100; valid_vec = 4'b1111;
    #1;
    check("hit_resp", 32'({mem_resp, way_sel, load_lru, lru_mru_way}), 32'b1_10_1_10);
    check("hit_no_pmem", 32'({pmem_read, pmem_write, write_sel, load_dirty}), 32'd0);
    nxt();

    // Write miss, way 2 invalid
    mem_read = 1'b0; mem_write = 1'b1; hit_vec = 4'b0; valid_vec = 4'b1011; dirty_vec = 4'b0;
    #1;
    check("wmiss_decide", 32'({mem_resp, load_tag, load_valid, load_dirty, load_lru, pmem_read, pmem_write}), 32'd0);
    nxt(); #1;
    check("wmiss_alloc", 32'({pmem_read, pmem_write, way_sel, addr_sel}), 32'b1_0_10_00);
    nxt(); pmem_resp = 1'b1; #1;
    check("wmiss_fill", 32'({load_tag, load_valid, set_valid, write_sel, load_dirty, set_dirty, mem_resp}),
          32'b0100_0100_1_01_0100_0_0);
    nxt(); pmem_resp = 1'b0; hit_vec = 4'b0100; valid_vec = 4'b1111; #1;
    check("wmiss_hit", 32'({mem_resp, way_sel, write_sel, load_dirty, set_dirty, pmem_read}),
          32'b1_10_10_0100_1_0);
    nxt();

    // Read miss with dirty LRU victim way 3
    mem_write = 1'b0; mem_read = 1'b1; hit_vec = 4'b0; valid_vec = 4'b1111; lru_victim = 2'd3;
    dirty_vec = 4'b1000;
    #1;
    check("rmiss_decide", 32'({mem_resp, pmem_read, pmem_write}), 32'd0);
    nxt(); #1;
    check("rmiss_wb", 32'({pmem_write, pmem_read, addr_sel, way_sel}), 32'b1_0_01_11);
    nxt(); pmem_resp = 1'b1; #1;
    check("rmiss_wb_done", 32'({pmem_write, load_dirty, set_dirty}), 32'b1_1000_0);
    nxt(); pmem_resp = 1'b0; dirty_vec = 4'b0; #1;
    check("rmiss_alloc", 32'({pmem_read, pmem_write, addr_sel, way_sel}), 32'b1_0_00_11);
    nxt(); pmem_resp = 1'b1; #1;
    check("rmiss_fill", 32'({load_tag, load_valid, write_sel}), 32'b1000_1000_01);
    nxt(); pmem_resp = 1'b0; hit_vec = 4'b1000; #1;
    check("rmiss_hit", 32'({mem_resp, way_sel, load_lru, lru_mru_way, write_sel}), 32'b1_11_1_11_00);
    nxt();

    // Flush request colliding with a read hit is dropped
    hit_vec = 4'b0001; flush_req = 1'b1; #1;
    check("flushcol_hit", 32'({mem_resp, way_sel, busy_flush}), 32'b1_00_0);
    nxt(); mem_read = 1'b0; flush_req = 1'b0; hit_vec = 4'b0; #1;
    check("flushcol_busy", 32'(busy_flush), 32'd0);
    nxt(); #1;
    check("flushcol_busy2", 32'({busy_flush, pmem_write}), 32'd0);
    nxt();

    // Reset asserted during a writeback
    mem_read = 1'b1; valid_vec = 4'b1111; dirty_vec = 4'b0001; lru_victim = 2'd0;
    nxt(); #1;
    check("rstwb_active", 32'(pmem_write), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstwb_outs", 32'(outs), 32'd0);
    nxt();
    mem_read = 1'b0; rst = 1'b1;
    nxt(); #1;
    check("rstwb_idle", 32'(outs), 32'd0);
    @(negedge clk);

    // Directed flush: dirty only at set3/way1 and set7/way3
    clear_arrays();
    for (int s = 0; s < 8; s++) begin
      evalid[s][0] = 1; etag[s][0] = s; gvalid[s][0] = 1; gtag[s][0] = s;
    end
    evalid[3][1] = 1; edirty[3][1] = 1; etag[3][1] = 9;
    gvalid[3][1] = 1; gdirty[3][1] = 1; gtag[3][1] = 9;
    evalid[7][3] = 1; edirty[7][3] = 1; etag[7][3] = 9;
    gvalid[7][3] = 1; gdirty[7][3] = 1; gtag[7][3] = 9;
    cur_set = 0; cur_tag = 15;
    drive_inputs();
    do_flush();
    check("dflush_wbs", 32'(nwb), 32'd2);
    compare_arrays();

    // Random traffic, then flush everything dirty
    for (int i = 0; i < 80; i++)
      do_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom_range(0, 5));
    compare_arrays();
    do_flush();
    compare_arrays();

    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule
